// File: rtl/chain_probe_pkg.sv
// chain_probe_pkg: shared JTAG constants, probe FSM state enum and TMS map.
// Exports NUM_SLOTS, TLR_LEN, IDCODE_LEN, state_t, tms_of(); no ports.
`include "definitions.sv"

package chain_probe_pkg;

  localparam int NUM_SLOTS  = `NUM_DEV + 1;
  localparam int TLR_LEN    = 5;
  localparam int IDCODE_LEN = 32;

  typedef enum logic [3:0] {
    IDLE,
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SHIFT,
    EXIT1,
    UPD,
    RTI_END,
    DONE
  } state_t;

  function automatic logic tms_of(input state_t s);
    logic v;
    unique case (s)
      RTI, CAP_DR, SHIFT, RTI_END: v = 1'b0;
      default:                     v = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/definitions.sv
// definitions: slot-count macros NUM_DEV / NUM_DEV_BITS for chain_probe.
// Slots are numbered 0..NUM_DEV; no ports.
`ifndef CHAIN_PROBE_DEFINITIONS_SV
`define CHAIN_PROBE_DEFINITIONS_SV
`ifndef NUM_DEV
`define NUM_DEV 3
`endif
`ifndef NUM_DEV_BITS
`define NUM_DEV_BITS 2
`endif
`endif

// File: rtl/probe_slot_check.sv
// probe_slot_check: per-slot TDO capture and present decision.
// Ports: clk, rst(n), clr, sample, lsb_en|id_en, tdo -> present [, idcode if CHAIN_PROBE_IDCODE_EN].
module probe_slot_check
  import chain_probe_pkg::*;
#(
  parameter int                 PAT_LEN = 8,
  parameter logic [PAT_LEN-1:0] PATTERN = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  sample,
`ifdef CHAIN_PROBE_IDCODE_EN
  input  logic                  id_en,
  output logic [IDCODE_LEN-1:0] idcode,
`else
  input  logic                  lsb_en,
`endif
  input  logic                  tdo,
  output logic                  present
);

  logic [PAT_LEN-1:0] pat_sr;
  logic               lsb;

  // Every sample is shifted in; only the last PAT_LEN remain.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      pat_sr <= '0;
    end else if (sample) begin
      pat_sr <= {tdo, pat_sr[PAT_LEN-1:1]};
    end
  end

`ifdef CHAIN_PROBE_IDCODE_EN
  logic [IDCODE_LEN-1:0] id_sr;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      id_sr <= '0;
    end else if (sample && id_en) begin
      id_sr <= {tdo, id_sr[IDCODE_LEN-1:1]};
    end
  end

  assign lsb    = id_sr[0];
  assign idcode = present ? id_sr : '0;
`else
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      lsb <= 1'b0;
    end else if (sample && lsb_en) begin
      lsb <= tdo;
    end
  end
`endif

  assign present = lsb && (pat_sr == PATTERN);

endmodule

// File: rtl/chain_probe.sv
// chain_probe: JTAG slot discovery; IDCODE LSB + echo pattern per slot.
// Ports: clk, rst(n), start -> tck, tms, tdi[], tdo[] in, active_chains, busy, done
// [, idcodes with CHAIN_PROBE_IDCODE_EN].
`include "definitions.sv"

module chain_probe
  import chain_probe_pkg::*;
#(
  parameter int                 PAT_LEN = 8,
  parameter logic [PAT_LEN-1:0] PATTERN = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   tck,
  output logic                   tms,
  output logic [`NUM_DEV:0]      tdi,
  input  logic [`NUM_DEV:0]      tdo,
  output logic [`NUM_DEV:0]      active_chains,
  output logic                   busy,
  output logic                   done
`ifdef CHAIN_PROBE_IDCODE_EN
  ,
  output logic [32*(`NUM_DEV+1)-1:0] idcodes
`endif
);

  localparam int TOT = IDCODE_LEN + PAT_LEN;
  localparam int CW  = $clog2(TOT + 1);
  localparam logic [TOT-1:0] SEQ = {PATTERN, {IDCODE_LEN{1'b0}}};

  state_t               state;
  state_t               nxt;
  logic [2:0]           cnt;
  logic [CW-1:0]        bit_cnt;
  logic [TOT-1:0]       tdi_sr;
  logic                 tdi_bit;
  logic                 running;
  logic                 accept;
  logic                 sample;
  logic [NUM_SLOTS-1:0] present;

  assign running = (state != IDLE) && (state != DONE);
  assign accept  = start && !busy
                && (state == IDLE || state == DONE);
  // tck is low before the edge that raises it: that is the sample edge.
  assign sample  = running && !tck
                && (state == SHIFT || state == EXIT1);
  assign tdi     = {NUM_SLOTS{tdi_bit}};

  always_comb begin
    nxt = state;
    unique case (state)
      TLR:     if (cnt == 3'(TLR_LEN - 1)) nxt = RTI;
      RTI:     nxt = SEL_DR;
      SEL_DR:  nxt = CAP_DR;
      CAP_DR:  nxt = SHIFT;
      SHIFT:   if (bit_cnt == CW'(TOT - 2)) nxt = EXIT1;
      EXIT1:   nxt = UPD;
      UPD:     nxt = RTI_END;
      RTI_END: nxt = DONE;
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      tck           <= 1'b0;
      tms           <= 1'b1;
      tdi_bit       <= 1'b0;
      cnt           <= '0;
      bit_cnt       <= '0;
      tdi_sr        <= '0;
      active_chains <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (accept) begin
      state         <= TLR;
      tck           <= 1'b0;
      tms           <= tms_of(TLR);
      tdi_bit       <= 1'b0;
      cnt           <= '0;
      bit_cnt       <= '0;
      active_chains <= '0;
      busy          <= 1'b1;
      done          <= 1'b0;
    end else if (state == DONE) begin
      // One settle clk after the last TCK period, then publish.
      if (busy) begin
        busy          <= 1'b0;
        done          <= 1'b1;
        active_chains <= present;
      end
    end else if (running) begin
      tck <= !tck;
      if (tck) begin
        state <= nxt;
        tms   <= tms_of(nxt);
        cnt   <= (state == TLR && nxt == TLR) ? cnt + 3'd1 : '0;
        if (state == CAP_DR) begin
          bit_cnt <= '0;
          tdi_bit <= SEQ[0];
          tdi_sr  <= SEQ >> 1;
        end else if (state == SHIFT) begin
          bit_cnt <= bit_cnt + CW'(1);
          tdi_bit <= tdi_sr[0];
          tdi_sr  <= tdi_sr >> 1;
        end else begin
          tdi_bit <= 1'b0;
        end
      end
    end
  end

`ifdef CHAIN_PROBE_IDCODE_EN
  logic [32*NUM_SLOTS-1:0] id_all;
  logic                    id_en;

  assign id_en   = bit_cnt < CW'(IDCODE_LEN);
  assign idcodes = done ? id_all : '0;
`else
  logic lsb_en;

  assign lsb_en = bit_cnt == '0;
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    probe_slot_check #(
      .PAT_LEN(PAT_LEN),
      .PATTERN(PATTERN)
    ) u_check (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .sample  (sample),
`ifdef CHAIN_PROBE_IDCODE_EN
      .id_en   (id_en),
      .idcode  (id_all[32*i +: 32]),
`else
      .lsb_en  (lsb_en),
`endif
      .tdo     (tdo[i]),
      .present (present[i])
    );
  end

endmodule

// File: doc/chain_probe.md
CHAIN_PROBE -- requirements
Module: chain_probe

Interface
REQ-001 SHALL take parameter PAT_LEN, default 8: length of the echo pattern shifted after the IDCODE.
REQ-002 SHALL take parameter PATTERN, default 8'hA5: echo pattern, shifted LSB first.
REQ-003 SHALL have clk, input, 1: logic clock, 40 MHz or less.
REQ-004 SHALL have rst, input, 1: reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have start, input, 1: single-cycle request to run a discovery pass.
REQ-006 SHALL have tck, output, 1: JTAG clock shared by all device slots.
REQ-007 SHALL have tms, output, 1: JTAG mode select shared by all device slots.
REQ-008 SHALL have tdi, output, `NUM_DEV+1: per-slot TDI, with every slot driven identically during a probe.
REQ-009 SHALL have tdo, input, `NUM_DEV+1: per-slot TDO; an absent slot reads 1 (pull-up).
REQ-010 SHALL have active_chains, output, `NUM_DEV+1: Daisy Chain Vector; bit i=1 means slot i is populated.
REQ-011 SHALL have busy, output, 1: a pass is in progress.
REQ-012 SHALL have done, output, 1: level signal; the pass is complete and active_chains is valid.

Function
REQ-013 SHALL generate tck as clk/2: it toggles every clk while busy and is held 0 otherwise.
REQ-014 SHALL change tms and tdi only on the clk edge that drives tck low.
REQ-015 SHALL sample tdo only on the clk edge that drives tck high.
REQ-016 SHALL use the FSM states IDLE, TLR, RTI, SEL_DR, CAP_DR, SHIFT, EXIT1, UPD, RTI_END, DONE.
REQ-017 SHALL hold each state for the following TCK periods and tms values: TLR 5 (tms=1), RTI 1 (0), SEL_DR 1 (1), CAP_DR 1 (0), SHIFT 32+PAT_LEN-1 (0), EXIT1 1 (1), UPD 1 (1), RTI_END 1 (0).
REQ-018 SHALL drive tdi=0 for the first 32 shifted bits, then PATTERN LSB first; tdi SHALL be 0 outside SHIFT/EXIT1.
REQ-019 SHALL, per slot, capture the first shifted tdo bit (IDCODE LSB) and the last PAT_LEN tdo bits.
REQ-020 SHALL set slot i present iff the IDCODE LSB was 1 and the last PAT_LEN bits equal PATTERN.
REQ-021 SHALL accept start only in IDLE or DONE; on acceptance, active_chains SHALL clear to 0, done SHALL go to 0, busy SHALL go to 1, and the FSM SHALL enter TLR.
REQ-022 SHALL ignore start while busy, with no restart.
REQ-023 SHALL assert done and deassert busy exactly 101 clk after the accepting edge (50 TCK periods plus 1), and SHALL load active_chains on that same edge.
REQ-024 SHALL hold done and active_chains stable in DONE until the next accepted start.
REQ-025 SHALL use bit counters wide enough for 32+PAT_LEN with no wrap; the shift counter SHALL reset on entry to SHIFT.

Reset
REQ-026 SHALL, on rst=0 at a clk edge, force state IDLE, tck=0, tms=1, tdi=0, active_chains=0, busy=0, done=0, and clear all counters and capture registers.
REQ-027 SHALL abort an in-progress pass when reset is asserted mid-pass; no partial active_chains SHALL be published.

Configuration
REQ-028 SHALL honour macro CHAIN_PROBE_IDCODE_EN; when it is defined, the block SHALL add output idcodes, 32*(`NUM_DEV+1) bits wide, holding each slot's 32 captured IDCODE bits (0 for absent slots), valid with done.
REQ-029 SHALL, when the macro is undefined, have no idcodes port, keep only bit 0 of the IDCODE capture, and leave all other behaviour identical.

Structure
REQ-030 SHALL include definitions.sv for `NUM_DEV/`NUM_DEV_BITS; the FSM state enum and the TLR/IDCODE lengths (5, 32) SHALL live in the shared JTAG package.
REQ-031 SHALL instantiate one sub-module, probe_slot_check, per slot, holding that slot's capture shift register and the present decision.
REQ-032 SHALL present active_chains in the same bit order as the downstream chain-index computation consumes.

Verification
REQ-033 Bench SHALL cover: all slots modelled as 32-bit IDCODE TAPs, start pulse -> active_chains all ones, done at +101 clk.
REQ-034 Bench SHALL cover: slots 0 and 2 populated, the rest open (tdo=1) -> active_chains = 0...0101.
REQ-035 Bench SHALL cover: a slot with tdo stuck at 0 -> that bit 0 (LSB check fails).
REQ-036 Bench SHALL cover: start re-pulsed at +40 clk -> ignored, done still at +101.
REQ-037 Bench SHALL cover: rst=0 at +60 clk -> tms=1, tck=0, busy=0, active_chains=0 on the next edge; a new start then completes normally.
REQ-038 Bench SHALL cover, with CHAIN_PROBE_IDCODE_EN: a slot with IDCODE 32'h1234_5679 -> idcodes slice equals 32'h1234_5679.
